vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
//  Shares the single-port 48K x 16 VRAM between two requesters: video scanout
//  (read-only, latency-critical) and the CPU bus (read/write, nibble-masked).
//  Sits between the CPU/video fabric and the VRAM instance.
//  Issues at most one access per cycle. Respects the VRAM read-mux constraint:
//  the bank bits must stay stable in the cycle the read data is returned.
// PARAMETERS
//  ADDR_W        16  word address width
//  DATA_W        16  data width
//  CPU_MAX_WAIT  8   starvation-guard threshold in cycles (used only with the macro)
// PORTS
//  clk            in   1       system clock
//  reset_n_i      in   1       asynchronous, active-low reset
//  vid_req_i      in   1       video read request; held with addr until gnt
//  vid_addr_i     in   ADDR_W  video word address
//  vid_gnt_o      out  1       video request accepted this cycle (combinational)
//  vid_rvalid_o   out  1       video read data valid
//  vid_rdata_o    out  DATA_W  video read data
//  cpu_req_i      in   1       CPU request; held with all fields until gnt
//  cpu_we_i       in   1       1 = write, 0 = read
//  cpu_mask_i     in   4       nibble write mask
//  cpu_addr_i     in   ADDR_W  CPU word address
//  cpu_wdata_i    in   DATA_W  CPU write data
//  cpu_gnt_o      out  1       CPU request accepted this cycle (combinational)
//  cpu_rvalid_o   out  1       CPU read data valid (never asserted for writes)
//  cpu_rdata_o    out  DATA_W  CPU read data
//  vram_sel_o     out  1       VRAM select (registered)
//  vram_wr_en_o   out  1       VRAM write enable (registered)
//  vram_wr_mask_o out  4       VRAM nibble mask (registered)
//  vram_addr_o    out  ADDR_W  VRAM address (registered)
//  vram_wdata_o   out  DATA_W  VRAM write data (registered)
//  vram_rdata_i   in   DATA_W  VRAM read data (valid the cycle after sel)
// BEHAVIOUR
//  - Reset: all outputs 0; issue and response pipeline flags cleared.
//  - Cycle N: grant, combinational. Edge N+1: access loaded into vram_*_o
//    (issue stage). Edge N+2: VRAM samples the access.
//    Cycle N+2: rvalid_o of the owner is high and rdata_o = vram_rdata_i.
//    Grant-to-rvalid latency is fixed at 2 cycles.
//  - Owner tag (NONE/VID/CPU, plus is_read) travels with the issue stage into
//    the response stage. A write never produces rvalid.
//  - Priority: video beats CPU on simultaneous requests. At most one gnt per
//    cycle. gnt is 0 whenever req is 0.
//  - Bank hold: when an access is in the issue stage, a new grant requires
//    addr[15:14] equal to the in-flight bank. Otherwise gnt = 0 for one cycle.
//  - No grant: vram_sel_o = 0 and vram_wr_en_o = 0. vram_addr_o keeps its
//    previous value (never cleared), so the bank stays stable during the
//    response cycle.
//  - Same-bank back-to-back accesses sustain 1 access/cycle.
//  - Bank 3 (addr >= 0xC000) is passed through unchanged. Reads there return
//    whatever the VRAM returns (0).
//  - Reset mid-operation: in-flight accesses are dropped, no rvalid afterwards,
//    and requesters re-issue.
// CONFIGURATION
//  VRAM_ARB_STARVE_GUARD_EN defined:
//    - A wait counter increments each cycle that cpu_req_i=1 and cpu_gnt_o=0,
//      saturating at CPU_MAX_WAIT.
//    - At CPU_MAX_WAIT the CPU wins the next grant over video (bank-hold rule
//      still applies).
//    - The counter clears on cpu_gnt_o.
//  Undefined: strict video priority; no counter logic.
// STRUCTURE
//  - vram_pkg: ADDR_W/DATA_W defaults, BANK_MSB=15, BANK_LSB=14,
//    typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU} vram_owner_t.
//  - Sub-module vram_arb_pick: combinational priority/bank-hold picker
//    producing grants.
//  - Top level holds the issue/response registers and the guard counter.
// TESTING
//  1. Video read 0x0010 (mem=0x1234) alone -> vid_gnt at N, vram_sel at N+1,
//     vid_rvalid with 0x1234 at N+2.
//  2. Video read 0x0100 + CPU write 0x0200=0xBEEF simultaneous -> vid_gnt N,
//     cpu_gnt N+1; later CPU read 0x0200 returns 0xBEEF, no rvalid on the write.
//  3. CPU reads 0x3FFF then 0x4000 back-to-back -> cpu_gnt low one cycle,
//     vram_addr_o bank held; both rvalids carry correct data.
//  4. Mem 0x0000=0x0000; write 0xABCD mask 4'b0101 -> readback 0x0B0D.
//  5. vid_req_i held 1 in bank 0 and cpu_req_i held 1 for 20 cycles ->
//     without macro no cpu_gnt; with macro cpu_gnt at wait count 8.
//  6. Assert reset_n_i=0 in the cycle after a video grant -> no vid_rvalid,
//     all outputs 0 until release.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM arbiter slice.
package vram_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned BANK_MSB   = 15;
    localparam int unsigned BANK_LSB   = 14;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VID,
        OWN_CPU
    } vram_owner_t;

    typedef struct packed {
        vram_owner_t owner;
        logic        is_read;
    } vram_tag_t;

    localparam vram_tag_t TAG_IDLE = '{owner: OWN_NONE, is_read: 1'b0};

    // A new access may start when nothing is in flight or it stays in the in-flight bank.
    function automatic logic bank_ok(input logic busy,
                                     input logic [1:0] bank,
                                     input logic [1:0] busy_bank);
        return !busy || (bank == busy_bank);
    endfunction

endpackage

// File: rtl/vram_arb_pick.sv
// Combinational grant picker: video-first priority (optionally overridden for a
// starving CPU), then the bank-hold check on the winner only.
module vram_arb_pick
    import vram_pkg::*;
(
    input  logic       enable,
    input  logic       vid_req,
    input  logic [1:0] vid_bank,
    input  logic       cpu_req,
    input  logic [1:0] cpu_bank,
    input  logic       cpu_first,
    input  logic       busy,
    input  logic [1:0] busy_bank,
    output logic       vid_gnt,
    output logic       cpu_gnt
);

    logic vid_wins;

    always_comb begin
        vid_gnt  = 1'b0;
        cpu_gnt  = 1'b0;
        vid_wins = vid_req && !(cpu_first && cpu_req);
        // A blocked winner stalls the cycle; the loser is not promoted.
        if (enable) begin
            if (vid_wins) begin
                vid_gnt = bank_ok(busy, vid_bank, busy_bank);
            end else if (cpu_req) begin
                cpu_gnt = bank_ok(busy, cpu_bank, busy_bank);
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Two-requester VRAM arbiter with issue and response stages.
// Optional CPU starvation guard: define VRAM_ARB_STARVE_GUARD_EN.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned CPU_MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset_n_i,
    input  logic              vid_req_i,
    input  logic [ADDR_W-1:0] vid_addr_i,
    output logic              vid_gnt_o,
    output logic              vid_rvalid_o,
    output logic [DATA_W-1:0] vid_rdata_o,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [3:0]        cpu_mask_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              vram_sel_o,
    output logic              vram_wr_en_o,
    output logic [3:0]        vram_wr_mask_o,
    output logic [ADDR_W-1:0] vram_addr_o,
    output logic [DATA_W-1:0] vram_wdata_o,
    input  logic [DATA_W-1:0] vram_rdata_i
);

    vram_tag_t issue_tag;
    vram_tag_t resp_tag;
    logic      cpu_first;

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam int unsigned WAIT_W = $clog2(CPU_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wait_cnt <= '0;
        end else if (cpu_gnt_o) begin
            wait_cnt <= '0;
        end else if (cpu_req_i && (wait_cnt != WAIT_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign cpu_first = (wait_cnt == WAIT_MAX);
`else
    assign cpu_first = 1'b0;
`endif

    vram_arb_pick u_pick (
        .enable    (reset_n_i),
        .vid_req   (vid_req_i),
        .vid_bank  (vid_addr_i[BANK_MSB:BANK_LSB]),
        .cpu_req   (cpu_req_i),
        .cpu_bank  (cpu_addr_i[BANK_MSB:BANK_LSB]),
        .cpu_first (cpu_first),
        .busy      (vram_sel_o),
        .busy_bank (vram_addr_o[BANK_MSB:BANK_LSB]),
        .vid_gnt   (vid_gnt_o),
        .cpu_gnt   (cpu_gnt_o)
    );

    // Address and data hold their last values on idle cycles so the bank
    // stays put while the VRAM read mux returns data.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            vram_sel_o     <= 1'b0;
            vram_wr_en_o   <= 1'b0;
            vram_wr_mask_o <= '0;
            vram_addr_o    <= '0;
            vram_wdata_o   <= '0;
            issue_tag      <= TAG_IDLE;
        end else begin
            vram_sel_o   <= vid_gnt_o | cpu_gnt_o;
            vram_wr_en_o <= cpu_gnt_o & cpu_we_i;
            if (vid_gnt_o) begin
                vram_addr_o    <= vid_addr_i;
                vram_wr_mask_o <= '0;
                issue_tag      <= '{owner: OWN_VID, is_read: 1'b1};
            end else if (cpu_gnt_o) begin
                vram_addr_o    <= cpu_addr_i;
                vram_wr_mask_o <= cpu_we_i ? cpu_mask_i : 4'b0000;
                vram_wdata_o   <= cpu_wdata_i;
                issue_tag      <= '{owner: OWN_CPU, is_read: !cpu_we_i};
            end else begin
                issue_tag      <= TAG_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            resp_tag <= TAG_IDLE;
        end else begin
            resp_tag <= issue_tag;
        end
    end

    always_comb begin
        vid_rvalid_o = (resp_tag.owner == OWN_VID) && resp_tag.is_read;
        cpu_rvalid_o = (resp_tag.owner == OWN_CPU) && resp_tag.is_read;
        vid_rdata_o  = vid_rvalid_o ? vram_rdata_i : '0;
        cpu_rdata_o  = cpu_rvalid_o ? vram_rdata_i : '0;
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed vector table, hand sequences,
// and randomized traffic against a transaction-level reference model.
module tb_vram_arbiter;

    localparam int unsigned MAX_WAIT = 8;
`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam bit GUARD          = 1'b1;
    localparam int EXP_FIRST_CPU  = 8;
    localparam int EXP_VID_GRANTS = 19;
`else
    localparam bit GUARD          = 1'b0;
    localparam int EXP_FIRST_CPU  = -1;
    localparam int EXP_VID_GRANTS = 20;
`endif

    logic        clk = 1'b0;
    logic        reset_n_i;
    logic        vid_req_i;
    logic [15:0] vid_addr_i;
    logic        vid_gnt_o, vid_rvalid_o;
    logic [15:0] vid_rdata_o;
    logic        cpu_req_i, cpu_we_i;
    logic [3:0]  cpu_mask_i;
    logic [15:0] cpu_addr_i, cpu_wdata_i;
    logic        cpu_gnt_o, cpu_rvalid_o;
    logic [15:0] cpu_rdata_o;
    logic        vram_sel_o, vram_wr_en_o;
    logic [3:0]  vram_wr_mask_o;
    logic [15:0] vram_addr_o, vram_wdata_o;
    logic [15:0] vram_rdata_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vram_arbiter #(.ADDR_W(16), .DATA_W(16), .CPU_MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset_n_i(reset_n_i),
        .vid_req_i(vid_req_i), .vid_addr_i(vid_addr_i), .vid_gnt_o(vid_gnt_o),
        .vid_rvalid_o(vid_rvalid_o), .vid_rdata_o(vid_rdata_o),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_mask_i(cpu_mask_i),
        .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i), .cpu_gnt_o(cpu_gnt_o),
        .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o),
        .vram_sel_o(vram_sel_o), .vram_wr_en_o(vram_wr_en_o), .vram_wr_mask_o(vram_wr_mask_o),
        .vram_addr_o(vram_addr_o), .vram_wdata_o(vram_wdata_o), .vram_rdata_i(vram_rdata_i)
    );

    // VRAM device model: 48K words, bank 3 unpopulated (reads 0, writes dropped).
    logic [15:0] vmem [0:49151];
    logic [15:0] vword;
    always @(posedge clk) begin
        if (vram_sel_o) begin
            if (vram_addr_o < 16'hC000) begin
                vword = vmem[vram_addr_o];
                if (vram_wr_en_o) begin
                    for (int n = 0; n < 4; n++)
                        if (vram_wr_mask_o[n]) vword[n*4 +: 4] = vram_wdata_o[n*4 +: 4];
                    vmem[vram_addr_o] <= vword;
                end
                vram_rdata_i <= vmem[vram_addr_o];
            end else begin
                vram_rdata_i <= '0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        vid_req_i = 1'b0; vid_addr_i = '0;
        cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_mask_i = '0; cpu_addr_i = '0; cpu_wdata_i = '0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_sel"},   {31'd0, vram_sel_o}, 32'd0);
        chk({nm, "_outs"},  {vid_gnt_o, vid_rvalid_o, cpu_gnt_o, cpu_rvalid_o, vram_wr_en_o,
                             vram_wr_mask_o, vram_addr_o, vram_wdata_o, vid_rdata_o, cpu_rdata_o} == '0, 32'd1);
    endtask

    typedef struct {
        logic vreq; logic [15:0] vaddr;
        logic creq; logic cwe; logic [3:0] cmask; logic [15:0] caddr; logic [15:0] cwdata;
        logic vgnt; logic cgnt;
        logic vrv;  logic [15:0] vrd;
        logic crv;  logic [15:0] crd;
        logic sel;  logic achk; logic [15:0] addr;
    } vec_t;

    function automatic vec_t mk(input logic vreq, input logic [15:0] vaddr,
                                input logic creq, input logic cwe, input logic [3:0] cmask,
                                input logic [15:0] caddr, input logic [15:0] cwdata,
                                input logic vgnt, input logic cgnt,
                                input logic vrv, input logic [15:0] vrd,
                                input logic crv, input logic [15:0] crd,
                                input logic sel, input logic achk, input logic [15:0] addr);
        vec_t t;
        t.vreq = vreq; t.vaddr = vaddr; t.creq = creq; t.cwe = cwe; t.cmask = cmask;
        t.caddr = caddr; t.cwdata = cwdata; t.vgnt = vgnt; t.cgnt = cgnt;
        t.vrv = vrv; t.vrd = vrd; t.crv = crv; t.crd = crd; t.sel = sel; t.achk = achk; t.addr = addr;
        return t;
    endfunction

    typedef struct {
        int          due;
        bit          is_vid;
        logic [15:0] data;
    } resp_t;

    function automatic logic [15:0] raddr();
        return {2'($urandom_range(0, 3)), 14'($urandom_range(0, 7))};
    endfunction

    vec_t        tbl [26];
    logic [15:0] shadow [0:49151];

    initial begin
        int          first_cpu, vid_cnt;
        logic        vp, cp, cwe_r, first, win_v, win_c, ev, ec, evr, prev_any;
        logic [15:0] va, ca, cwd, d;
        logic [3:0]  cm;
        logic [1:0]  prev_bank;
        int          wcnt;
        resp_t       q[$];
        resp_t       r;

        for (int a = 0; a < 49152; a++) vmem[a] = '0;
        vmem[16'h0010] = 16'h1234; vmem[16'h0100] = 16'h5A5A; vmem[16'h3FFF] = 16'h1111;
        vmem[16'h4000] = 16'h2222; vmem[16'h8000] = 16'h3333; vmem[16'h0001] = 16'h4444;
        vram_rdata_i = '0;

        //            vreq vaddr   creq we mask caddr   cwdata  vg cg vrv vrd     crv crd     sel achk addr
        tbl[0]  = mk(1, 16'h0010, 0, 0, 4'h0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000);
        tbl[1]  = mk(0, 16'h0000, 0, 0, 4'h0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0010);
        tbl[2]  = mk(0, 16'h0000, 0, 0, 4'h0, 16'h0000, 16'h0000, 0, 0, 1, 16'h1234, 0, 16'h0000, 0, 0, 16'h0000);
        tbl[3]  = mk(1, 16'h0100, 1, 1, 4'hF, 16'h0200, 16'hBEEF, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000);
        tbl[4]  = mk(0, 16'h0000, 1, 1, 4'hF, 16'h0200, 16'hBEEF, 0, 1, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0100);
        tbl[5]  = mk(0, 16'h0000, 0, 0, 4'h0, 16'h0000, 16'h0000, 0, 0, 1, 16'h5A5A, 0, 16'h0000, 1, 1, 16'h0200);
        tbl[6]  = mk(0, 16'h0000, 1, 0, 4'h0, 16'h0200, 16'h0000, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000);
        tbl[7]  = mk(0, 16'h0000, 0, 0, 4'h0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0200);
        tbl[8]  = mk(0, 16'h0000, 0, 0, 4'h0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'hBEEF, 0, 0, 16'h0000);
        tbl[9]  = mk(0, 16'h0000, 1, 0, 4'h0, 16'h3FFF, 16'h0000, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000);
        tbl[10] = mk(0, 16'h0000, 1, 0, 4'h0, 16'h4000, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h3FFF);
        tbl[11] = mk(0, 16'h0000, 1, 0, 4'h0, 16'h4000, 16'h0000, 0, 1, 0, 16'h0000, 1, 16'h1111, 0, 1, 16'h3FFF);
        tbl[12] = mk(0, 16'h0000, 0, 0, 4'h0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h4000);
        tbl[13] = mk(0, 16'h0000, 0, 0, 4'h0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'h2222, 0, 0, 16'h0000);
        tbl[14] = mk(0, 16'h0000, 1, 1, 4'h5, 16'h0000, 16'hABCD, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000);
        tbl[15] = mk(0, 16'h0000, 1, 0, 4'h0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0000);
        tbl[16] = mk(0, 16'h0000, 0, 0, 4'h0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0000);
        tbl[17] = mk(0, 16'h0000, 0, 0, 4'h0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'h0B0D, 0, 0, 16'h0000);
        tbl[18] = mk(1, 16'hC004, 0, 0, 4'h0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000);
        tbl[19] = mk(0, 16'h0000, 0, 0, 4'h0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'hC004);
        tbl[20] = mk(0, 16'h0000, 0, 0, 4'h0, 16'h0000, 16'h0000, 0, 0, 1, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000);
        tbl[21] = mk(0, 16'h0000, 1, 0, 4'h0, 16'h8000, 16'h0000, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000);
        tbl[22] = mk(1, 16'h0001, 0, 0, 4'h0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h8000);
        tbl[23] = mk(1, 16'h0001, 0, 0, 4'h0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 1, 16'h3333, 0, 0, 16'h0000);
        tbl[24] = mk(0, 16'h0000, 0, 0, 4'h0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0001);
        tbl[25] = mk(0, 16'h0000, 0, 0, 4'h0, 16'h0000, 16'h0000, 0, 0, 1, 16'h4444, 0, 16'h0000, 0, 0, 16'h0000);

        // Reset state
        reset_n_i = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1 chk_all_zero("reset");
        @(posedge clk); #1 reset_n_i = 1'b1;

        // Directed vector table
        for (int i = 0; i < 26; i++) begin
            vid_req_i = tbl[i].vreq; vid_addr_i = tbl[i].vaddr;
            cpu_req_i = tbl[i].creq; cpu_we_i = tbl[i].cwe; cpu_mask_i = tbl[i].cmask;
            cpu_addr_i = tbl[i].caddr; cpu_wdata_i = tbl[i].cwdata;
            @(negedge clk);
            chk($sformatf("vec%0d_vid_gnt", i), {31'd0, vid_gnt_o}, {31'd0, tbl[i].vgnt});
            chk($sformatf("vec%0d_cpu_gnt", i), {31'd0, cpu_gnt_o}, {31'd0, tbl[i].cgnt});
            chk($sformatf("vec%0d_vid_rvalid", i), {31'd0, vid_rvalid_o}, {31'd0, tbl[i].vrv});
            chk($sformatf("vec%0d_cpu_rvalid", i), {31'd0, cpu_rvalid_o}, {31'd0, tbl[i].crv});
            chk($sformatf("vec%0d_sel", i), {31'd0, vram_sel_o}, {31'd0, tbl[i].sel});
            if (tbl[i].vrv) chk($sformatf("vec%0d_vid_rdata", i), {16'd0, vid_rdata_o}, {16'd0, tbl[i].vrd});
            if (tbl[i].crv) chk($sformatf("vec%0d_cpu_rdata", i), {16'd0, cpu_rdata_o}, {16'd0, tbl[i].crd});
            if (tbl[i].achk) chk($sformatf("vec%0d_vram_addr", i), {16'd0, vram_addr_o}, {16'd0, tbl[i].addr});
            @(posedge clk); #1;
        end

        // Continuous video traffic against a waiting CPU read
        first_cpu = -1;
        vid_cnt = 0;
        vid_req_i = 1'b1; vid_addr_i = 16'h0020;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 16'h0030;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (vid_gnt_o) vid_cnt++;
            if (cpu_gnt_o && first_cpu < 0) first_cpu = k;
            @(posedge clk); #1;
            if (first_cpu >= 0) cpu_req_i = 1'b0;
        end
        chk("starve_first_cpu_gnt", 32'(first_cpu), 32'(EXP_FIRST_CPU));
        chk("starve_vid_gnt_count", 32'(vid_cnt), 32'(EXP_VID_GRANTS));
        idle_inputs();
        repeat (4) @(posedge clk);
        #1;

        // Reset in the cycle after a video grant
        vid_req_i = 1'b1; vid_addr_i = 16'h0010;
        @(negedge clk);
        chk("rst_pre_vid_gnt", {31'd0, vid_gnt_o}, 32'd1);
        @(posedge clk); #1;
        reset_n_i = 1'b0;
        #1 chk_all_zero("rst_assert");
        @(negedge clk) chk_all_zero("rst_held");
        @(posedge clk); #1;
        vid_req_i = 1'b0;
        @(negedge clk) chk_all_zero("rst_held2");
        @(posedge clk); #1 reset_n_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst_after%0d", k), {vid_rvalid_o, cpu_rvalid_o, vram_sel_o}, 32'd0);
            @(posedge clk); #1;
        end

        // Randomized traffic against the transaction-level model
        for (int a = 0; a < 49152; a++) shadow[a] = vmem[a];
        vp = 1'b0; cp = 1'b0; cwe_r = 1'b0; va = '0; ca = '0; cwd = '0; cm = '0;
        prev_any = 1'b0; prev_bank = '0; wcnt = 0;
        for (int c = 0; c < 2000; c++) begin
            if (!vp && c < 1980 && $urandom_range(0, 2) == 0) begin
                vp = 1'b1; va = raddr();
            end
            if (!cp && c < 1980 && $urandom_range(0, 2) == 0) begin
                cp = 1'b1; ca = raddr(); cwe_r = 1'($urandom_range(0, 1));
                cm = 4'($urandom_range(0, 15)); cwd = 16'($urandom);
            end
            vid_req_i = vp; vid_addr_i = va;
            cpu_req_i = cp; cpu_we_i = cwe_r; cpu_mask_i = cm; cpu_addr_i = ca; cpu_wdata_i = cwd;

            first = GUARD && cp && (wcnt >= int'(MAX_WAIT));
            win_v = vp && !first;
            win_c = cp && !win_v;
            ev = win_v && (!prev_any || va[15:14] == prev_bank);
            ec = win_c && (!prev_any || ca[15:14] == prev_bank);
            evr = (q.size() > 0) && (q[0].due == c);

            @(negedge clk);
            chk("rnd_vid_gnt", {31'd0, vid_gnt_o}, {31'd0, ev});
            chk("rnd_cpu_gnt", {31'd0, cpu_gnt_o}, {31'd0, ec});
            chk("rnd_sel", {31'd0, vram_sel_o}, {31'd0, prev_any});
            if (evr) begin
                r = q.pop_front();
                chk("rnd_vid_rvalid", {31'd0, vid_rvalid_o}, {31'd0, r.is_vid});
                chk("rnd_cpu_rvalid", {31'd0, cpu_rvalid_o}, {31'd0, !r.is_vid});
                chk("rnd_rdata", {16'd0, (r.is_vid ? vid_rdata_o : cpu_rdata_o)}, {16'd0, r.data});
            end else begin
                chk("rnd_no_rvalid", {30'd0, vid_rvalid_o, cpu_rvalid_o}, 32'd0);
            end

            if (ev) begin
                d = (va < 16'hC000) ? shadow[va] : 16'h0000;
                q.push_back('{due: c + 2, is_vid: 1'b1, data: d});
                vp = 1'b0;
            end
            if (ec) begin
                if (cwe_r) begin
                    if (ca < 16'hC000) begin
                        d = shadow[ca];
                        for (int n = 0; n < 4; n++) if (cm[n]) d[n*4 +: 4] = cwd[n*4 +: 4];
                        shadow[ca] = d;
                    end
                end else begin
                    d = (ca < 16'hC000) ? shadow[ca] : 16'h0000;
                    q.push_back('{due: c + 2, is_vid: 1'b0, data: d});
                end
                cp = 1'b0;
                wcnt = 0;
            end else if (cp && wcnt < int'(MAX_WAIT)) begin
                wcnt++;
            end
            prev_any = ev || ec;
            if (ev) prev_bank = va[15:14];
            else if (ec) prev_bank = ca[15:14];

            @(posedge clk); #1;
        end
        chk("rnd_queue_drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
